// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the shift-add multiply / restoring divide sequencer.
package muldiv_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int         ITER     = 16;
  localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL     = 3'd1,
    ST_DIV_CMP = 3'd2,
    ST_DIV_SUB = 3'd3,
    ST_DONE    = 3'd4
  } state_t;
endpackage

// File: rtl/muldiv_if.sv
// Start/done coprocessor bus between the core pipeline and the mul/div sequencer.
interface muldiv_if #(parameter int WIDTH = 16);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             div_by_zero;

  modport master (output start, op, a, b,
                  input  busy, done, result_lo, result_hi, zero, div_by_zero);
  modport slave  (input  start, op, a, b,
                  output busy, done, result_lo, result_hi, zero, div_by_zero);
endinterface

// File: rtl/alu.sv
// Single-cycle datapath ALU; slt is an unsigned compare returning 1 or 0.
module alu
  import muldiv_pkg::*;
#(parameter int WIDTH = 16)
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_cntrl,
  output logic [WIDTH-1:0] result
);
  always_comb begin
    result = '0;
    case (alu_cntrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply (low half) and restoring divide, one ALU op per cycle.
module alu_muldiv_seq
  import muldiv_pkg::*;
#(parameter int WIDTH = 16)
(
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, rem_q, quo_q, divisor_q;
  logic [4:0]       cnt_q;
  logic             ge_q;
  logic [WIDTH-1:0] result_lo_q, result_hi_q;
  logic             zero_q, dbz_q;

  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [2:0]       alu_cntrl;
  logic [WIDTH-1:0] rem_s, acc_next, rem_next, quo_next;
  logic             accept, last;

  assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
  assign last   = (cnt_q == CNT_LAST);

  // rem < 2^k before step k, so the shifted-in remainder never overflows WIDTH bits
  assign rem_s    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign acc_next = mplier_q[0] ? alu_y : acc_q;
  assign rem_next = ge_q ? alu_y : rem_s;
  assign quo_next = {quo_q[WIDTH-2:0], ge_q};

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_cntrl = ALU_ADD;
    case (state_q)
      ST_MUL:     begin alu_a = acc_q; alu_b = mcand_q;   alu_cntrl = ALU_ADD; end
      ST_DIV_CMP: begin alu_a = rem_s; alu_b = divisor_q; alu_cntrl = ALU_SLT; end
      ST_DIV_SUB: begin alu_a = rem_s; alu_b = divisor_q; alu_cntrl = ALU_SUB; end
      default:    ;
    endcase
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a         (alu_a),
    .b         (alu_b),
    .alu_cntrl (alu_cntrl),
    .result    (alu_y)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (!bus.start)             state_d = ST_IDLE;
        else if (bus.op == OP_MUL)  state_d = ST_MUL;
        else if (bus.b == '0)       state_d = ST_DONE;
        else                        state_d = ST_DIV_CMP;
      end
      ST_MUL:     if (last) state_d = ST_DONE;
      ST_DIV_CMP: state_d = ST_DIV_SUB;
      ST_DIV_SUB: state_d = last ? ST_DONE : ST_DIV_CMP;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      ge_q        <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      if (bus.op == OP_MUL) begin
        acc_q    <= '0;
        mcand_q  <= bus.a;
        mplier_q <= bus.b;
      end else if (bus.b != '0) begin
        rem_q     <= '0;
        quo_q     <= bus.a;
        divisor_q <= bus.b;
      end else begin
        result_lo_q <= '1;
        result_hi_q <= bus.a;
        zero_q      <= 1'b0;
        dbz_q       <= 1'b1;
      end
    end else begin
      case (state_q)
        ST_MUL: begin
          acc_q    <= acc_next;
          mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + 5'd1;
          if (last) begin
            result_lo_q <= acc_next;
            result_hi_q <= '0;
            zero_q      <= (acc_next == '0);
            dbz_q       <= 1'b0;
          end
        end
        ST_DIV_CMP: ge_q <= (alu_y == '0);
        ST_DIV_SUB: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 5'd1;
          if (last) begin
            result_lo_q <= quo_next;
            result_hi_q <= rem_next;
            zero_q      <= (quo_next == '0);
            dbz_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q == ST_MUL) || (state_q == ST_DIV_CMP) || (state_q == ST_DIV_SUB);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.result_lo   = result_lo_q;
  assign bus.result_hi   = result_hi_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle sequencer that computes unsigned 16-bit multiply (low half) and unsigned 16-bit divide (quotient and remainder) by driving one instance of the existing `alu` block. Each cycle issues exactly one ALU operation: add, sub or set-less-than. It sits beside the single-cycle datapath as a start/done coprocessor. The core pipeline stalls on `busy` and reads `result_lo`, `result_hi` and `zero` when `done` pulses.

## Interface
- `WIDTH`, 16: operand and result width, fixed by the ALU datapath width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert and active-low.
- `start`  in  1: request, sampled only when the state is IDLE or DONE.
- `op`  in  1: operation select; 0 = MUL, 1 = DIV. Sampled with `start`.
- `a`  in  16: multiplicand or dividend, sampled with `start`.
- `b`  in  16: multiplier or divisor, sampled with `start`.
- `busy`  out  1: high while in MUL, DIV_CMP or DIV_SUB.
- `done`  out  1: one-cycle pulse, high only in DONE.
- `result_lo`  out  16: MUL = low 16 bits of a*b; DIV = quotient.
- `result_hi`  out  16: MUL = 0; DIV = remainder.
- `zero`  out  1: registered (`result_lo == 0`).
- `div_by_zero`  out  1: set with the results when DIV was issued with b == 0.

## Operation
- The internal `alu` instance is the only adder/comparator. Each operation's ALU inputs and `alu_cntrl` code:
  - MUL: add `3'b000` on acc and mcand.
  - DIV_CMP: set-less-than `3'b100` on rem_s and divisor.
  - DIV_SUB: sub `3'b001` on rem_s and divisor.
- Working registers: acc, mcand, mplier, rem, quo, divisor, cnt[4:0].
- States are IDLE, MUL, DIV_CMP, DIV_SUB and DONE.
- **IDLE/DONE + start, op = MUL:**
  - Set acc = 0, mcand = a, mplier = b, cnt = 0.
  - Go to MUL.
- **MUL** (one step per cycle):
  - If mplier[0] = 1, acc <= ALU sum (acc + mcand, mod 2^16).
  - mcand <<= 1, mplier >>= 1, cnt++.
  - After the step with cnt == 15, go to DONE.
- **IDLE/DONE + start, op = DIV, b != 0:**
  - Set rem = 0, quo = a, divisor = b, cnt = 0.
  - Go to DIV_CMP.
- **DIV_CMP:**
  - rem_s = {rem[14:0], quo[15]}, a combinational value.
  - Register ge = (ALU result == 0), meaning rem_s >= divisor.
  - Go to DIV_SUB.
- **DIV_SUB:**
  - rem <= ge ? ALU difference : rem_s.
  - quo <= {quo[14:0], ge}, cnt++.
  - After cnt == 15, go to DONE; otherwise go to DIV_CMP.
- **Width invariant:** before step k, rem < 2^k. Therefore rem_s always fits in 16 bits and no carry bit is needed.
- **DIV with b == 0:**
  - Go directly to DONE with result_lo = 16'hFFFF, result_hi = a, div_by_zero = 1.
  - The ALU is not exercised.
- **DONE:**
  - Output registers load on entry to DONE and hold until the next entry to DONE.
  - Unconditional exit to IDLE, or straight into a new operation if start = 1.
- `start` while `busy` is ignored. Inputs `a`, `b` and `op` may change freely after acceptance.

## Timing
- Reset values: state = IDLE; busy, done, zero and div_by_zero = 0; result_lo and result_hi = 0; all working registers = 0.
- Edge 0 is the edge that accepts `start`.
  - MUL: `done` is high in cycle 17, i.e. after edge 16.
  - DIV: `done` is high after edge 32.
  - DIV by zero: `done` is high after edge 0, a latency of 1.
- `busy` rises after edge 0 and falls on the same edge that raises `done`.
- Results are valid in the `done` cycle and stay stable afterwards.
- Back-to-back: start held high in DONE gives a gap of 0 idle cycles between operations.
- rst_n low in any state aborts the operation immediately. `done` is not produced, and outputs return to their reset values asynchronously.

## Structure
- Shared package `muldiv_pkg`:
  - ALU control constants ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_SLT = 3'b100.
  - OP_MUL = 1'b0, OP_DIV = 1'b1.
  - State encodings.
  - ITER = 16.
- One sub-module: the existing `alu`, instantiated once and driven by a per-state mux for a, b and alu_cntrl.
- FSM, counter and working registers live in `alu_muldiv_seq` itself.

## Test plan
- MUL a = 300, b = 200 -> done after edge 16; result_lo = 16'hEA60, result_hi = 0, zero = 0.
- MUL a = 16'h1234, b = 16'h0100 -> result_lo = 16'h3400, which checks truncation; second case MUL 16'h0100 * 16'h0100 -> result_lo = 0, zero = 1.
- DIV a = 1000, b = 7 -> done after edge 32; result_lo = 142, result_hi = 6.
- DIV a = 16'hFFFF, b = 16'h8001 -> quotient 1, remainder 16'h7FFE; second case DIV 5 / 9 -> quotient 0, remainder 5, zero = 1.
- DIV a = 5, b = 0 -> done after edge 0; result_lo = 16'hFFFF, result_hi = 5, div_by_zero = 1, busy never rises.
- Reset and `start` handling:
  - Start a DIV, pulse rst_n low at cycle 10 -> all outputs 0 immediately, no done; a new MUL 3 * 4 gives 12.
  - A `start` pulse issued mid-operation is ignored.
  - `start` held in DONE launches the next operation with no idle cycle.
